// File: rtl/cp0_pkg.sv
// Shared definitions for coprocessor 0: register numbers, exception codes,
// SR/Cause field positions and the exception handler entry address.
package cp0_pkg;

  // CP0 register numbers as seen by mfc0/mtc0
  localparam logic [4:0] REG_SR    = 5'd12;
  localparam logic [4:0] REG_CAUSE = 5'd13;
  localparam logic [4:0] REG_EPC   = 5'd14;

  // Exception codes carried in Cause.ExcCode
  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  // SR field positions
  localparam int SR_IM_LSB = 10;
  localparam int SR_IM_MSB = 15;
  localparam int SR_EXL    = 1;
  localparam int SR_IE     = 0;

  // Cause field positions
  localparam int CAUSE_BD      = 31;
  localparam int CAUSE_IP_LSB  = 10;
  localparam int CAUSE_IP_MSB  = 15;
  localparam int CAUSE_EXC_LSB = 2;
  localparam int CAUSE_EXC_MSB = 6;

  // Exception handler entry; consumed by the PC mux
  localparam logic [31:0] HANDLER_ADDR = 32'h0000_4180;

  // Assemble the architectural SR view; undefined bits read as zero
  function automatic logic [31:0] pack_sr(input logic [5:0] im,
                                          input logic       exl,
                                          input logic       ie);
    logic [31:0] v;
    v                       = '0;
    v[SR_IM_MSB:SR_IM_LSB]  = im;
    v[SR_EXL]               = exl;
    v[SR_IE]                = ie;
    return v;
  endfunction

  // Assemble the architectural Cause view; undefined bits read as zero
  function automatic logic [31:0] pack_cause(input logic       bd,
                                             input logic [5:0] ip,
                                             input logic [4:0] exc_code);
    logic [31:0] v;
    v                                 = '0;
    v[CAUSE_BD]                       = bd;
    v[CAUSE_IP_MSB:CAUSE_IP_LSB]      = ip;
    v[CAUSE_EXC_MSB:CAUSE_EXC_LSB]    = exc_code;
    return v;
  endfunction

endpackage

// File: rtl/cp0.sv
// Coprocessor 0: SR, Cause and EPC registers plus the per-cycle decision of
// whether the M-stage instruction is taken into the exception handler.
module cp0
  import cp0_pkg::*;
#(
  parameter logic [31:0] HANDLER_ADDR = cp0_pkg::HANDLER_ADDR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [4:0]  CP0Add,
  input  logic [31:0] CP0In,
  output logic [31:0] CP0Out,
  input  logic [31:0] VPC,
  input  logic        BDIn,
  input  logic [4:0]  ExcCodeIn,
  input  logic [5:0]  HWInt,
  input  logic        EXLClr,
  output logic [31:0] EPCOut,
  output logic        Req
);

  // SR fields
  logic [5:0]  im;
  logic        exl;
  logic        ie;
  // Cause fields
  logic        bd;
  logic [5:0]  ip;
  logic [4:0]  exc_code;
  // EPC
  logic [31:0] epc;

  logic        int_req;
  logic        exc_req;
  logic [31:0] sr_view;
  logic [31:0] cause_view;

  // Request decision: an enabled, unmasked interrupt or any pending
  // exception, all blocked while already inside the handler
  always_comb begin
    int_req = (|(HWInt & im)) & ie & ~exl;
    exc_req = (ExcCodeIn != EXC_INT) & ~exl;
    Req     = int_req | exc_req;
  end

  assign sr_view    = pack_sr(im, exl, ie);
  assign cause_view = pack_cause(bd, ip, exc_code);
  assign EPCOut     = epc;

  // mfc0 read mux
  always_comb begin
    // NOTE: default first so every path assigns CP0Out and no latch is inferred
    CP0Out = '0;
    unique case (CP0Add)
      REG_SR:    CP0Out = sr_view;
      REG_CAUSE: CP0Out = cause_view;
      REG_EPC:   CP0Out = epc;
      default:   CP0Out = '0;
    endcase
  end

  // IP tracks the interrupt lines every cycle; pulses between edges are
  // never captured
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep all registers updating from the
    // same pre-edge values regardless of block ordering
    if (reset) ip <= '0;
    else       ip <= HWInt;
  end

  // Exception entry has priority over eret, which has priority over mtc0
  always_ff @(posedge clk) begin
    if (reset) begin
      im       <= '0;
      exl      <= 1'b0;
      ie       <= 1'b0;
      bd       <= 1'b0;
      exc_code <= EXC_INT;
      epc      <= '0;
    end else if (Req) begin
      exl      <= 1'b1;
      bd       <= BDIn;
      exc_code <= int_req ? EXC_INT : ExcCodeIn;
      epc      <= BDIn ? (VPC - 32'd4) : VPC;
    end else if (EXLClr) begin
      exl <= 1'b0;
    end else if (en) begin
      // Cause is read-only; unmapped addresses are ignored
      if (CP0Add == REG_SR) begin
        im  <= CP0In[SR_IM_MSB:SR_IM_LSB];
        exl <= CP0In[SR_EXL];
        ie  <= CP0In[SR_IE];
      end else if (CP0Add == REG_EPC) begin
        epc <= CP0In;
      end
    end
  end

endmodule

// File: tb/tb_cp0.sv
// Directed self-checking bench for cp0 with hand-computed expected values.
module tb_cp0;
  import cp0_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [4:0]  CP0Add;
  logic [31:0] CP0In;
  logic [31:0] CP0Out;
  logic [31:0] VPC;
  logic        BDIn;
  logic [4:0]  ExcCodeIn;
  logic [5:0]  HWInt;
  logic        EXLClr;
  logic [31:0] EPCOut;
  logic        Req;

  int n_vec  = 0;
  int n_miss = 0;

  cp0 dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .CP0Add    (CP0Add),
    .CP0In     (CP0In),
    .CP0Out    (CP0Out),
    .VPC       (VPC),
    .BDIn      (BDIn),
    .ExcCodeIn (ExcCodeIn),
    .HWInt     (HWInt),
    .EXLClr    (EXLClr),
    .EPCOut    (EPCOut),
    .Req       (Req)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", tag, act, exp);
    end
  endtask

  // Advance one edge; inputs change 1 time unit after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Read a CP0 register through the combinational mfc0 port
  task automatic check_reg(input string tag, input logic [4:0] addr,
                           input logic [31:0] exp);
    CP0Add = addr;
    #1;
    check(tag, CP0Out, exp);
  endtask

  task automatic mtc0(input logic [4:0] addr, input logic [31:0] data);
    en = 1'b1; CP0Add = addr; CP0In = data;
    step();
    en = 1'b0; CP0In = '0;
  endtask

  task automatic eret();
    EXLClr = 1'b1;
    step();
    EXLClr = 1'b0;
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; CP0Add = '0; CP0In = '0; VPC = '0;
    BDIn = 1'b0; ExcCodeIn = '0; HWInt = '0; EXLClr = 1'b0;
    step(); step();
    reset = 1'b0;

    // Reset state
    check("rst_req", {31'd0, Req}, 32'd0);
    check("rst_epcout", EPCOut, 32'd0);
    check_reg("rst_sr", REG_SR, 32'd0);
    check_reg("rst_cause", REG_CAUSE, 32'd0);
    check_reg("rst_epc", REG_EPC, 32'd0);

    // Enable timer interrupt and fire it
    mtc0(REG_SR, 32'h0000_0401);
    check_reg("sr_write", REG_SR, 32'h0000_0401);
    check("idle_req", {31'd0, Req}, 32'd0);
    HWInt = 6'b000001; VPC = 32'h0000_3000;
    #1;
    check("timer_req", {31'd0, Req}, 32'd1);
    step();
    check_reg("timer_sr", REG_SR, 32'h0000_0403);
    check_reg("timer_cause", REG_CAUSE, 32'h0000_0400);
    check("timer_epc", EPCOut, 32'h0000_3000);

    // EXL masks interrupts and exceptions until the eret edge
    HWInt = 6'h3F; ExcCodeIn = EXC_ADEL;
    #1;
    check("exl_mask", {31'd0, Req}, 32'd0);
    EXLClr = 1'b1;
    #1;
    check("exl_mask_eret", {31'd0, Req}, 32'd0);
    step();
    EXLClr = 1'b0;
    check_reg("eret_sr", REG_SR, 32'h0000_0401);
    check("post_eret_req", {31'd0, Req}, 32'd1);
    VPC = 32'h0000_4000;
    step();
    check_reg("post_eret_cause", REG_CAUSE, 32'h0000_FC00);
    check("post_eret_epc", EPCOut, 32'h0000_4000);

    // Interrupt beats exception
    HWInt = '0; ExcCodeIn = '0;
    eret();
    mtc0(REG_SR, 32'h0000_1001);
    check_reg("im2_sr", REG_SR, 32'h0000_1001);
    HWInt = 6'b000001;
    #1;
    check("im_masked", {31'd0, Req}, 32'd0);
    HWInt = 6'b000100; ExcCodeIn = EXC_RI; VPC = 32'h0000_5000;
    #1;
    check("prio_req", {31'd0, Req}, 32'd1);
    step();
    check_reg("prio_cause", REG_CAUSE, 32'h0000_1000);
    check("prio_epc", EPCOut, 32'h0000_5000);

    // Exception in a delay slot with IE = 0
    HWInt = '0; ExcCodeIn = '0;
    eret();
    mtc0(REG_SR, 32'h0000_0000);
    ExcCodeIn = EXC_OV; BDIn = 1'b1; VPC = 32'h0000_3010;
    #1;
    check("bd_req", {31'd0, Req}, 32'd1);
    step();
    ExcCodeIn = '0; BDIn = 1'b0;
    check_reg("bd_cause", REG_CAUSE, 32'h8000_0030);
    check("bd_epc", EPCOut, 32'h0000_300C);
    check_reg("bd_sr", REG_SR, 32'h0000_0002);

    // Cause is read-only; unmapped reads return 0
    mtc0(REG_CAUSE, 32'hFFFF_FFFF);
    check_reg("cause_ro", REG_CAUSE, 32'h8000_0030);
    check_reg("unmapped_rd", 5'd5, 32'd0);

    // mtc0 EPC suppressed by a simultaneous Req
    eret();
    en = 1'b1; CP0Add = REG_EPC; CP0In = 32'h0000_3000;
    ExcCodeIn = EXC_ADES; VPC = 32'h0000_6000;
    step();
    en = 1'b0; ExcCodeIn = '0;
    check("epc_supp", EPCOut, 32'h0000_6000);
    check_reg("ades_cause", REG_CAUSE, 32'h0000_0014);

    // Plain EPC write lands next cycle
    mtc0(REG_EPC, 32'h0000_1234);
    check("epc_write", EPCOut, 32'h0000_1234);

    // Reset mid-handler, then reset winning over a live Req
    HWInt = 6'b000011;
    reset = 1'b1;
    step();
    HWInt = '0;
    ExcCodeIn = EXC_ADEL; VPC = 32'h0000_7000;
    #1;
    check("rst_req_live", {31'd0, Req}, 32'd1);
    step();
    reset = 1'b0; ExcCodeIn = '0;
    check_reg("rst2_sr", REG_SR, 32'd0);
    check_reg("rst2_cause", REG_CAUSE, 32'd0);
    check("rst2_epc", EPCOut, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/cp0.md
# cp0

Coprocessor 0 for the pipelined MIPS core: holds SR, Cause and EPC and decides each cycle whether the instruction in M stage is taken into the exception/interrupt handler. It consumes the 6-bit `HWInt` vector assembled at the top level (`{3'b0, interrupt, TC1_IRQ, TC0_IRQ}`) together with the exception code piped down from F/D/E. It produces `Req`, which flushes the pipeline and redirects fetch to the handler, and `EPCOut`, the return target used by `eret`.

## Interface
Parameters:
- `HANDLER_ADDR`, 32'h0000_4180: handler entry; exported for the PC mux, not used internally.

Ports:
- `clk`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  reset is synchronous and active-high.
- `en`  in  1  mtc0 write enable from M stage.
- `CP0Add`  in  5  register number for mfc0/mtc0.
- `CP0In`  in  32  mtc0 write data.
- `CP0Out`  out  32  mfc0 read data, combinational.
- `VPC`  in  32  PC of the M-stage instruction (victim PC).
- `BDIn`  in  1  M-stage instruction is in a branch delay slot.
- `ExcCodeIn`  in  5  exception code of the M-stage instruction; 0 means none.
- `HWInt`  in  6  hardware interrupt lines, level-sensitive.
- `EXLClr`  in  1  `eret` in M stage.
- `EPCOut`  out  32  current EPC register.
- `Req`  out  1  take exception/interrupt this cycle, combinational.

## Operation
- SR (reg 12): IM = bits[15:10], EXL = bit[1], IE = bit[0]. All other bits read as 0.
- Cause (reg 13): BD = bit[31], IP = bits[15:10], ExcCode = bits[6:2]. All other bits read as 0. Read-only to mtc0.
- EPC (reg 14): full 32 bits, writable.
- Reads of any other `CP0Add` return 0. Writes to any other address, or to Cause, are ignored.
- Request logic:
  - IntReq = |(HWInt & IM) & IE & ~EXL.
  - ExcReq = (ExcCodeIn != 0) & ~EXL.
  - Req = IntReq | ExcReq.
- Priority: an interrupt beats a synchronous exception.
  - On IntReq, ExcCode is set to 0 (Int).
  - Otherwise ExcCode is set to ExcCodeIn.
- On Req (edge):
  - EXL is set to 1.
  - BD is set to BDIn.
  - EPC is set to BDIn ? VPC−4 : VPC.
  - The mtc0 write and EXLClr in the same cycle are suppressed.
- Else if EXLClr: EXL is set to 0.
- Else if `en`: write CP0In to SR (mask to defined bits) or EPC.
- IP is set to HWInt every cycle, regardless of Req or EXL.
- ExcCode codes: 0 Int, 4 AdEL, 5 AdES, 10 RI, 12 Ov. Other values pass through unchecked.

## Timing
- Reset (sync): SR = 0, Cause = 0, EPC = 0. So `EPCOut` = 0, `CP0Out` = 0 and `Req` = 0 unless ExcCodeIn ≠ 0 with EXL = 0.
- `Req`, `CP0Out` and `EPCOut` are combinational from current state plus inputs; there is no added latency.
- New SR/EPC values are visible on `CP0Out`/`EPCOut` the cycle after the write edge. Forwarding mtc0 EPC to a following `eret` is handled by D-stage stall logic, not here.
- EXL = 1 masks all further requests, both interrupts and exceptions, until the `eret` edge. The first cycle after that edge may raise Req again.
- Edge cases:
  - An interrupt asserted and deasserted between edges is never latched.
  - `reset` high in the same cycle as Req: reset wins.

## Structure
- Shared package `cp0_pkg`:
  - register numbers SR = 12, CAUSE = 13, EPC = 14;
  - ExcCode constants;
  - SR/Cause bit-field positions;
  - `HANDLER_ADDR`.
- Single flat module; no sub-module is warranted. Three registers plus one request block.

## Test plan
- Enable and fire timer: mtc0 SR ← 32'h0000_0401, then HWInt = 6'b000001 → Req = 1 the same cycle. Next cycle: SR = 32'h0000_0403, Cause = 32'h0000_0400, EPC = VPC.
- Exception in a delay slot: ExcCodeIn = 12, BDIn = 1, VPC = 32'h3010 → Cause = 32'h8000_0030 and EPC = 32'h300C, even with IE = 0.
- Interrupt beats exception: IM = 6'b000100, IE = 1, HWInt[2] = 1, ExcCodeIn = 10 same cycle → ExcCode = 0.
- EXL masks requests: while EXL = 1, HWInt = 6'h3F and ExcCodeIn = 4 → Req = 0. Then EXLClr → EXL = 0 next cycle, and Req = 1 the following cycle.
- Write filtering and reset:
  - mtc0 Cause ← 32'hFFFF_FFFF → Cause unchanged.
  - mtc0 EPC ← 32'h3000 together with Req → EPC = VPC, not 32'h3000.
  - reset mid-handler → SR, Cause and EPC = 0.
